msi_snoop_arbiter: RTL and testbench

- Two-core coherence bus controller. Arbitrates between the two per-core cache controllers' bus requests (BusRd, BusRdX, Upgrade, WriteBack).
- Sequences each granted transaction: snoop of the other core's msi_cache (search / invalidate / downgrade), optional dirty flush to memory, memory line read, completion handshake.
- Sits between the two msi_cache instances, their miss controllers and the shared 64-bit-line memory port.

---
 rtl/msi_snoop_arbiter_if.sv | 43 ++++
 rtl/msi_snoop_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_msi_snoop_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msi_snoop_arbiter_if.sv
// Bus bundle between msi_snoop_arbiter, the two cores' miss controllers,
// the two msi_cache snoop ports and the shared line memory.
//   master : the arbiter (drives grants, snoop strobes, memory requests)
//   slave  : everything around it (requests, snoop responses, memory)
// cmd encoding: 00 BUSRD, 01 BUSRDX, 10 UPGR, 11 WB.
// snp_state encoding: 00 INVALID, 01 SHARED, 10 MODIFIED.
interface msi_snoop_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  cmd0, cmd1;
  logic [10:0] addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [63:0] rd_data;
  logic [1:0]  snp_search;
  logic [10:0] snp_addr;
  logic [1:0]  snp_found;
  logic [1:0]  snp_state0, snp_state1;
  logic [63:0] snp_data0, snp_data1;
  logic [1:0]  snp_inval;
  logic [1:0]  snp_dgrade;
  logic        mem_re, mem_we;
  logic [10:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_rdy;

  modport master (
    input  req, cmd0, cmd1, addr0, addr1, wdata0, wdata1,
           snp_found, snp_state0, snp_state1, snp_data0, snp_data1,
           mem_rdata, mem_rdy,
    output gnt, done, rd_data, snp_search, snp_addr, snp_inval, snp_dgrade,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req, cmd0, cmd1, addr0, addr1, wdata0, wdata1,
           snp_found, snp_state0, snp_state1, snp_data0, snp_data1,
           mem_rdata, mem_rdy,
    input  gnt, done, rd_data, snp_search, snp_addr, snp_inval, snp_dgrade,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/msi_snoop_arbiter.sv
// Two-core MSI coherence bus controller. Arbitrates the cores' bus
// requests, snoops the other core's cache, flushes dirty lines, reads
// memory and hands the granted core a one-cycle done pulse.
// Ports:
//   clk    system clock, all state changes on posedge
//   rst_n  asynchronous active-low reset
//   bus    msi_snoop_arbiter_if.master (requests, snoop, memory)
// Parameters:
//   SNP_LAT  cycles snp_search is held before the snoop response is sampled (1..15)
//   RR_EN    1 = round-robin between cores, 0 = core 0 always wins
module msi_snoop_arbiter #(
  parameter int unsigned SNP_LAT = 1,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  msi_snoop_arbiter_if.master  bus
);
  typedef enum logic [2:0] {IDLE, SNOOP, FLUSH, MEM_WR, MEM_RD, INVAL, DGRADE, DONE} state_t;

  localparam logic [1:0] C_RD   = 2'b00;
  localparam logic [1:0] C_RDX  = 2'b01;
  localparam logic [1:0] C_UPGR = 2'b10;
  localparam logic [1:0] C_WB   = 2'b11;
  localparam logic [1:0] ST_MOD = 2'b10;
  localparam logic [3:0] LAT_M1 = 4'(SNP_LAT - 1);

  state_t      r_state;
  logic        r_g;      // granted core
  logic        r_last;   // last granted core
  logic [1:0]  r_cmd;
  logic [10:0] r_addr;
  logic        r_found;
  logic [3:0]  r_cnt;
  logic [1:0]  r_gnt, r_done, r_snp_search, r_snp_inval, r_snp_dgrade;
  logic [63:0] r_rd_data, r_mem_wdata;
  logic [10:0] r_snp_addr, r_mem_addr;
  logic        r_mem_re, r_mem_we;

  logic        w_pick;
  logic [1:0]  w_cmd;
  logic [10:0] w_addr;
  logic [63:0] w_wdata;
  logic        w_o_found, w_o_mod;
  logic [1:0]  w_o_state, w_o_hot;
  logic [63:0] w_o_data;

  // With both requesting, round-robin hands the bus to the core not served last.
  assign w_pick  = (bus.req == 2'b11) ? (RR_EN ? ~r_last : 1'b0) : bus.req[1];
  assign w_cmd   = w_pick ? bus.cmd1   : bus.cmd0;
  assign w_addr  = w_pick ? bus.addr1  : bus.addr0;
  assign w_wdata = w_pick ? bus.wdata1 : bus.wdata0;

  // Snoop responses always come from the non-granted core.
  assign w_o_found = r_g ? bus.snp_found[0] : bus.snp_found[1];
  assign w_o_state = r_g ? bus.snp_state0   : bus.snp_state1;
  assign w_o_data  = r_g ? bus.snp_data0    : bus.snp_data1;
  assign w_o_hot   = r_g ? 2'b01 : 2'b10;
  assign w_o_mod   = w_o_found && (w_o_state == ST_MOD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_g          <= 1'b0;
      r_last       <= 1'b1;
      r_cmd        <= C_RD;
      r_addr       <= '0;
      r_found      <= 1'b0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_snp_search <= '0;
      r_snp_inval  <= '0;
      r_snp_dgrade <= '0;
      r_rd_data    <= '0;
      r_mem_wdata  <= '0;
      r_snp_addr   <= '0;
      r_mem_addr   <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      r_done       <= '0;
      r_snp_inval  <= '0;
      r_snp_dgrade <= '0;
      unique case (r_state)
        IDLE: if (|bus.req) begin
          r_g        <= w_pick;
          r_gnt      <= w_pick ? 2'b10 : 2'b01;
          r_cmd      <= w_cmd;
          r_addr     <= w_addr;
          r_snp_addr <= w_addr;
          if (w_cmd == C_WB) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_state     <= MEM_WR;
          end else begin
            r_snp_search <= w_pick ? 2'b01 : 2'b10;
            r_cnt        <= LAT_M1;
            r_state      <= SNOOP;
          end
        end
        SNOOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_snp_search <= '0;
            r_found      <= w_o_found;
            if (w_o_mod) begin
              // Dirty copy elsewhere: it is both the returned line and the flush data.
              r_rd_data   <= w_o_data;
              r_mem_wdata <= w_o_data;
              r_mem_addr  <= r_addr;
              r_mem_we    <= 1'b1;
              r_state     <= FLUSH;
            end else if (r_cmd == C_UPGR) begin
              if (w_o_found) begin
                r_snp_inval <= w_o_hot;
                r_state     <= INVAL;
              end else begin
                r_done  <= r_gnt;
                r_state <= DONE;
              end
            end else begin
              r_mem_addr <= r_addr;
              r_mem_re   <= 1'b1;
              r_state    <= MEM_RD;
            end
          end
        end
        FLUSH: if (bus.mem_rdy) begin
          r_mem_we <= 1'b0;
          if (r_cmd == C_RD) begin
            r_snp_dgrade <= w_o_hot;
            r_state      <= DGRADE;
          end else begin
            r_snp_inval <= w_o_hot;
            r_state     <= INVAL;
          end
        end
        MEM_WR: if (bus.mem_rdy) begin
          r_mem_we <= 1'b0;
          r_done   <= r_gnt;
          r_state  <= DONE;
        end
        MEM_RD: if (bus.mem_rdy) begin
          r_mem_re  <= 1'b0;
          r_rd_data <= bus.mem_rdata;
          if (r_cmd == C_RDX && r_found) begin
            r_snp_inval <= w_o_hot;
            r_state     <= INVAL;
          end else begin
            r_done  <= r_gnt;
            r_state <= DONE;
          end
        end
        INVAL, DGRADE: begin
          r_done  <= r_gnt;
          r_state <= DONE;
        end
        DONE: begin
          r_gnt   <= '0;
          r_last  <= r_g;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.done       = r_done;
  assign bus.rd_data    = r_rd_data;
  assign bus.snp_search = r_snp_search;
  assign bus.snp_addr   = r_snp_addr;
  assign bus.snp_inval  = r_snp_inval;
  assign bus.snp_dgrade = r_snp_dgrade;
  assign bus.mem_re     = r_mem_re;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_msi_snoop_arbiter.sv
// Scoreboard bench for msi_snoop_arbiter. u_dut (SNP_LAT=1, round-robin)
// is surrounded by behavioural caches and a memory; u_dut2 (SNP_LAT=3,
// fixed priority) sees empty caches and an always-ready memory.
module tb_msi_snoop_arbiter;
  localparam logic [1:0] RD = 2'b00, RDX = 2'b01, UPGR = 2'b10, WB = 2'b11;
  localparam logic [1:0] SI = 2'b00, SS = 2'b01, SM = 2'b10;
  localparam logic [63:0] MEM2_DATA = 64'h1234_5678_9ABC_DEF0;

  typedef struct {
    int          core;
    logic [10:0] addr;
    bit          chk_rd;
    logic [63:0] rd;
    int          lat;
    int          n_rd, n_wr, n_inv, n_dg, n_srch;
    logic [1:0]  ost;
    logic [63:0] mem;
    int          t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msi_snoop_arbiter_if bif();
  msi_snoop_arbiter_if bif2();

  msi_snoop_arbiter #(.SNP_LAT(1), .RR_EN(1'b1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bif));
  msi_snoop_arbiter #(.SNP_LAT(3), .RR_EN(1'b0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bif2));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int mem_dly = 0;
  bit mem_hold = 1'b0;
  logic [1:0]  csta [2][2048];
  logic [63:0] cdat [2][2048];
  logic [63:0] memd [2048];
  logic [63:0] ref_mem [2048];
  exp_t exq[$];
  exp_t exq2[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: the outcome of one transaction from the MSI bus rules.
  function automatic exp_t mk(input int core, input logic [1:0] cmd, input logic [10:0] a,
                              input logic [63:0] w, input int dly, input bit cl);
    exp_t e;
    logic [1:0]  s = csta[1-core][a];
    logic [63:0] d = cdat[1-core][a];
    bit dirty = (s == SM);
    e.core   = core;
    e.addr   = a;
    e.chk_rd = (cmd == RD) || (cmd == RDX);
    e.rd     = dirty ? d : ref_mem[a];
    e.n_wr   = (cmd == WB || dirty) ? 1 : 0;
    e.n_rd   = (e.chk_rd && !dirty) ? 1 : 0;
    e.n_inv  = ((cmd == RDX || cmd == UPGR) && s != SI) ? 1 : 0;
    e.n_dg   = (cmd == RD && dirty) ? 1 : 0;
    e.n_srch = (cmd == WB) ? 0 : 1;
    e.ost    = (cmd == WB) ? s : (e.n_inv == 1) ? SI : (e.n_dg == 1) ? SS : s;
    if (cmd == WB) ref_mem[a] = w;
    else if (dirty) ref_mem[a] = d;
    e.mem = ref_mem[a];
    e.lat = cl ? e.n_srch + (e.n_rd + e.n_wr) * (1 + dly) + e.n_inv + e.n_dg + 1 : -1;
    e.t0  = cyc;
    return e;
  endfunction

  task automatic drv(input bit d2, input int c, input logic [1:0] cmd, input logic [10:0] a,
                     input logic [63:0] w, input bit r);
    if (!d2) begin
      if (c == 0) begin bif.cmd0 = cmd; bif.addr0 = a; bif.wdata0 = w; end
      else        begin bif.cmd1 = cmd; bif.addr1 = a; bif.wdata1 = w; end
      bif.req[c] = r;
    end else begin
      if (c == 0) begin bif2.cmd0 = cmd; bif2.addr0 = a; bif2.wdata0 = w; end
      else        begin bif2.cmd1 = cmd; bif2.addr1 = a; bif2.wdata1 = w; end
      bif2.req[c] = r;
    end
  endtask

  task automatic wait_done(input bit d2, input int c, input int bound);
    bit got = 1'b0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      got = d2 ? bif2.done[c] : bif.done[c];
    end
    chk($sformatf("done_in_time_core%0d", c), 64'(got), 64'd1);
  endtask

  task automatic do_txn(input int c, input logic [1:0] cmd, input logic [10:0] a,
                        input logic [63:0] w, input int dly, input bit cl);
    exp_t e;
    mem_dly = dly;
    e = mk(c, cmd, a, w, dly, cl);
    exq.push_back(e);
    drv(0, c, cmd, a, w, 1'b1);
    wait_done(0, c, 100);
    drv(0, c, cmd, a, w, 1'b0);
    @(negedge clk);
  endtask

  task automatic seq_wb(input bit d2, input int c, input int n);
    for (int j = 0; j < n; j++) begin
      drv(d2, c, WB, 11'(11'h100 + c * 16 + j), {32'(c), 32'(j)} ^ 64'hC0DE_0000_F00D_0000, 1'b1);
      wait_done(d2, c, 60);
    end
    drv(d2, c, WB, 11'h0, 64'h0, 1'b0);
  endtask

  // Behavioural caches and memory around u_dut.
  initial begin
    int wcnt = 0;
    bif.mem_rdy = 1'b0;
    bif.mem_rdata = '0;
    bif.snp_found = '0;
    bif.snp_state0 = SI; bif.snp_state1 = SI;
    bif.snp_data0 = '0;  bif.snp_data1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bif.mem_rdy = 1'b0;
        wcnt = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (bif.snp_inval[i])  csta[i][bif.snp_addr] = SI;
          if (bif.snp_dgrade[i]) csta[i][bif.snp_addr] = SS;
        end
        if (bif.mem_rdy) begin
          bif.mem_rdy = 1'b0;
          bif.mem_rdata = {$urandom, $urandom};
          wcnt = 0;
        end else if ((bif.mem_re || bif.mem_we) && !mem_hold) begin
          if (wcnt >= mem_dly) begin
            bif.mem_rdy = 1'b1;
            if (bif.mem_we) memd[bif.mem_addr] = bif.mem_wdata;
            else bif.mem_rdata = memd[bif.mem_addr];
          end else wcnt++;
        end
        for (int i = 0; i < 2; i++) bif.snp_found[i] = (csta[i][bif.snp_addr] != SI);
        bif.snp_state0 = csta[0][bif.snp_addr];
        bif.snp_state1 = csta[1][bif.snp_addr];
        bif.snp_data0  = cdat[0][bif.snp_addr];
        bif.snp_data1  = cdat[1][bif.snp_addr];
      end
    end
  end

  // Scoreboard monitor for u_dut.
  initial begin
    int c_rd = 0, c_wr = 0, c_inv = 0, c_dg = 0, s_o = 0, s_g = 0;
    logic p_re = 1'b0, p_we = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        c_rd = 0; c_wr = 0; c_inv = 0; c_dg = 0; s_o = 0; s_g = 0;
        p_re = 1'b0; p_we = 1'b0;
      end else begin
        if (bif.mem_re && !p_re) c_rd++;
        if (bif.mem_we && !p_we) c_wr++;
        p_re = bif.mem_re;
        p_we = bif.mem_we;
        if (bif.snp_inval != 2'b00)  c_inv++;
        if (bif.snp_dgrade != 2'b00) c_dg++;
        if ((bif.snp_search & ~bif.gnt) != 2'b00) s_o++;
        if ((bif.snp_search & bif.gnt) != 2'b00)  s_g++;
        for (int i = 0; i < 2; i++)
          if (bif.gnt[i] && !bif.req[i] && !bif.done[i])
            chk($sformatf("req_held_core%0d", i), 64'(bif.req[i]), 64'd1);
        if (bif.done != 2'b00) begin
          if (exq.size() == 0) chk("unexpected_done", 64'(bif.done), 64'd0);
          else begin
            e = exq.pop_front();
            chk("done_core", 64'(bif.done), (e.core == 1) ? 64'd2 : 64'd1);
            if (e.chk_rd) chk("rd_data", bif.rd_data, e.rd);
            if (e.lat >= 0) chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            chk("inval_cnt", 64'(c_inv), 64'(e.n_inv));
            chk("dgrade_cnt", 64'(c_dg), 64'(e.n_dg));
            chk("memrd_cnt", 64'(c_rd), 64'(e.n_rd));
            chk("memwr_cnt", 64'(c_wr), 64'(e.n_wr));
            chk("snoop_cycles", 64'(s_o), 64'(e.n_srch));
            chk("self_snoop", 64'(s_g), 64'd0);
            chk("mem_line", memd[e.addr], e.mem);
            chk("other_state", 64'(csta[1-e.core][e.addr]), 64'(e.ost));
          end
          c_rd = 0; c_wr = 0; c_inv = 0; c_dg = 0; s_o = 0; s_g = 0;
        end
      end
    end
  end

  // Monitor for u_dut2: grant order, latency and returned line.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bif2.done != 2'b00) begin
        if (exq2.size() == 0) chk("unexpected_done2", 64'(bif2.done), 64'd0);
        else begin
          e = exq2.pop_front();
          chk("done2_core", 64'(bif2.done), (e.core == 1) ? 64'd2 : 64'd1);
          if (e.lat >= 0) chk("latency2", 64'(cyc - e.t0), 64'(e.lat));
          if (e.chk_rd) chk("rd_data2", bif2.rd_data, e.rd);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int c;
    logic [1:0] cm;
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) begin
      memd[i] = {$urandom, $urandom};
      ref_mem[i] = memd[i];
      csta[0][i] = SI; csta[1][i] = SI;
      cdat[0][i] = {$urandom, $urandom};
      cdat[1][i] = {$urandom, $urandom};
    end
    bif.req = '0;  bif.cmd0 = RD;  bif.cmd1 = RD;  bif.addr0 = '0;  bif.addr1 = '0;
    bif.wdata0 = '0;  bif.wdata1 = '0;
    bif2.req = '0; bif2.cmd0 = RD; bif2.cmd1 = RD; bif2.addr0 = '0; bif2.addr1 = '0;
    bif2.wdata0 = '0; bif2.wdata1 = '0;
    bif2.snp_found = '0; bif2.snp_state0 = SI; bif2.snp_state1 = SI;
    bif2.snp_data0 = '0; bif2.snp_data1 = '0;
    bif2.mem_rdata = MEM2_DATA;
    bif2.mem_rdy = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(bif.gnt), 64'd0);
    chk("rst_done", 64'(bif.done), 64'd0);
    chk("rst_mem", 64'({bif.mem_re, bif.mem_we}), 64'd0);
    chk("rst_snoop", 64'({bif.snp_search, bif.snp_inval, bif.snp_dgrade}), 64'd0);
    chk("rst_rd_data", bif.rd_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin: both cores stream WBs, grants must alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      c = k % 2;
      e = mk(c, WB, 11'(11'h100 + c * 16 + k / 2),
             {32'(c), 32'(k / 2)} ^ 64'hC0DE_0000_F00D_0000, 0, 1'b0);
      exq.push_back(e);
    end
    fork
      seq_wb(1'b0, 0, 2);
      seq_wb(1'b0, 1, 2);
    join
    @(negedge clk);

    // Fixed priority with SNP_LAT=3: core 0 keeps winning while it requests.
    for (int k = 0; k < 4; k++) exq2.push_back('{core: 0, addr: 0, chk_rd: 0, rd: 0, lat: -1,
      n_rd: 0, n_wr: 0, n_inv: 0, n_dg: 0, n_srch: 0, ost: SI, mem: 0, t0: 0});
    exq2.push_back('{core: 1, addr: 0, chk_rd: 0, rd: 0, lat: -1,
      n_rd: 0, n_wr: 0, n_inv: 0, n_dg: 0, n_srch: 0, ost: SI, mem: 0, t0: 0});
    fork
      seq_wb(1'b1, 0, 4);
      seq_wb(1'b1, 1, 1);
    join
    @(negedge clk);
    exq2.push_back('{core: 1, addr: 0, chk_rd: 1, rd: MEM2_DATA, lat: 5,
      n_rd: 0, n_wr: 0, n_inv: 0, n_dg: 0, n_srch: 0, ost: SI, mem: 0, t0: cyc});
    drv(1'b1, 1, RD, 11'h055, 64'h0, 1'b1);
    wait_done(1'b1, 1, 30);
    drv(1'b1, 1, RD, 11'h055, 64'h0, 1'b0);
    @(negedge clk);

    // Directed cases with an immediately ready memory.
    memd[11'h045] = 64'hDEAD_BEEF_0123_4567; ref_mem[11'h045] = 64'hDEAD_BEEF_0123_4567;
    do_txn(0, RD, 11'h045, 64'h0, 0, 1'b1);
    csta[0][11'h1C3] = SM; cdat[0][11'h1C3] = 64'hA5A5_A5A5_A5A5_A5A5;
    do_txn(1, RDX, 11'h1C3, 64'h0, 0, 1'b1);
    csta[1][11'h233] = SM; cdat[1][11'h233] = 64'h0F0F_1234_5678_0F0F;
    do_txn(0, RD, 11'h233, 64'h0, 0, 1'b1);
    csta[1][11'h077] = SS;
    do_txn(0, UPGR, 11'h077, 64'h0, 0, 1'b1);
    do_txn(0, UPGR, 11'h078, 64'h0, 0, 1'b1);
    do_txn(1, WB, 11'h3FF, 64'h1111_2222_3333_4444, 0, 1'b1);
    csta[0][11'h300] = SM; cdat[0][11'h300] = 64'h5555_6666_7777_8888;
    do_txn(1, UPGR, 11'h300, 64'h0, 0, 1'b1);

    // Randomized traffic against the reference.
    for (int n = 0; n < 40; n++) begin
      c  = int'($urandom_range(1));
      cm = 2'($urandom_range(3));
      a  = 11'($urandom_range(2047));
      csta[1-c][a] = 2'($urandom_range(2));
      cdat[1-c][a] = {$urandom, $urandom};
      do_txn(c, cm, a, {$urandom, $urandom}, int'($urandom_range(2)), 1'b1);
    end

    // Reset in the middle of a memory read abandons it.
    csta[1][11'h2AA] = SI;
    mem_hold = 1'b1;
    drv(1'b0, 0, RD, 11'h2AA, 64'h0, 1'b1);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        seen = bif.mem_re;
      end
      chk("memrd_before_reset", 64'(seen), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 64'(bif.gnt), 64'd0);
    chk("midrst_mem_re", 64'(bif.mem_re), 64'd0);
    chk("midrst_outs", 64'({bif.done, bif.snp_search, bif.snp_inval, bif.snp_dgrade, bif.mem_we}), 64'd0);
    chk("midrst_addr", 64'({bif.mem_addr, bif.snp_addr}), 64'd0);
    chk("midrst_rd_data", bif.rd_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    mem_hold = 1'b0;
    mem_dly = 0;
    e = mk(0, RD, 11'h2AA, 64'h0, 0, 1'b1);
    exq.push_back(e);
    rst_n = 1'b1;
    wait_done(1'b0, 0, 30);
    drv(1'b0, 0, RD, 11'h2AA, 64'h0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exq.size()), 64'd0);
    chk("scoreboard2_empty", 64'(exq2.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
